mul_share_arb: RTL and testbench

Two-requester arbiter and pipeline controller that time-shares one n×n signed-or-unsigned multiplier. Each requester sends operand pairs with a per-request signedness bit over a valid/ready channel. The block picks one requester per cycle and pushes the operands through a two-stage registered multiply pipeline. It returns each 2n-bit product on a single response channel with backpressure, tagged with the requester id. It sits between compute clients and the shared combinational multiply datapath in the arithmetic section.

---
 rtl/mul_share_arb.sv | 96 +++++++++
 tb/tb_mul_share_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: two-requester arbiter feeding a shared two-stage registered n x n multiply pipeline.
// Optional macro MUL_SHARE_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module mul_share_arb #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [n-1:0]   req0_a,
    input  logic [n-1:0]   req0_b,
    input  logic           req0_signed,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [n-1:0]   req1_a,
    input  logic [n-1:0]   req1_b,
    input  logic           req1_signed,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*n-1:0] rsp_res
);
    logic           v1, v2, s1, id1, id2;
    logic [n-1:0]   a1, b1;
    logic [2*n-1:0] res2, ea, eb, prod;
    logic           adv1, adv2, g0, g1, acc, acc_id;

    assign adv2 = !v2 | rsp_ready;
    assign adv1 = !v1 | adv2;

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
    assign g0 = req0_valid;
    assign g1 = req1_valid & !req0_valid;
`else
    logic last;
    assign g0 = req0_valid & (!req1_valid | last);
    assign g1 = req1_valid & (!req0_valid | !last);

    // remember the most recently accepted requester for round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (acc)
            last <= acc_id;
    end
`endif

    // readies are forced low while reset is held
    assign req0_ready = rst_n & g0 & adv1;
    assign req1_ready = rst_n & g1 & adv1;
    assign acc        = req0_ready | req1_ready;
    assign acc_id     = g1;

    // extend to 2n then multiply; low 2n bits are exact for both signed and unsigned
    assign ea   = s1 ? {{n{a1[n-1]}}, a1} : {{n{1'b0}}, a1};
    assign eb   = s1 ? {{n{b1[n-1]}}, b1} : {{n{1'b0}}, b1};
    assign prod = ea * eb;

    // S1 operand register: loads the accepted request whenever it can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            s1  <= 1'b0;
            id1 <= 1'b0;
        end else if (adv1) begin
            v1 <= acc;
            if (acc) begin
                a1  <= acc_id ? req1_a : req0_a;
                b1  <= acc_id ? req1_b : req0_b;
                s1  <= acc_id ? req1_signed : req0_signed;
                id1 <= acc_id;
            end
        end
    end

    // S2 product register: drives the response channel directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            res2 <= '0;
            id2  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res2 <= prod;
                id2  <= id1;
            end
        end
    end

    assign rsp_valid = v2;
    assign rsp_id    = id2;
    assign rsp_res   = res2;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed and randomized checks of mul_share_arb against a queue-based product model.
module tb_mul_share_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_signed = 1'b0, req1_signed = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [15:0] rsp_res;

    int n_cmp = 0, n_err = 0;
    logic [16:0] exp_q[$];
    logic        rsp_log[$];
    logic        m_last = 1'b1;
    logic        acc0 = 1'b0, acc1 = 1'b0;

    mul_share_arb #(.n(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_signed(req0_signed),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_signed(req1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    // scoreboard: records acceptances, checks arbitration and every response in order
    always @(negedge clk) begin
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (rst_n) begin
            chk("grant_onehot", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_valid & req1_valid & (acc0 | acc1))
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
                chk("arb_winner", {31'b0, acc1}, 0);
`else
                chk("arb_winner", {31'b0, acc1}, {31'b0, ~m_last});
`endif
            if (acc0) exp_q.push_back({1'b0, ref_mul(req0_a, req0_b, req0_signed)});
            if (acc1) exp_q.push_back({1'b1, ref_mul(req1_a, req1_b, req1_signed)});
            if (acc0 | acc1) m_last = acc1;
            if (rsp_valid & rsp_ready) begin
                rsp_log.push_back(rsp_id);
                if (exp_q.size() == 0)
                    chk("spurious_rsp", 1, 0);
                else
                    chk("rsp_id_res", {15'b0, rsp_id, rsp_res}, {15'b0, exp_q.pop_front()});
            end
        end
    end

    // in-flight products vanish on reset
    always @(negedge rst_n) begin
        exp_q.delete();
        m_last = 1'b1;
    end

    task automatic drive(input bit id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_signed = s; end
        else begin req0_valid = v; req0_a = a; req0_b = b; req0_signed = s; end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", {31'b0, k >= 30}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c, k, i0, i1;
        logic [15:0] held;
        logic        ord[$];
        logic        exp_ord[8];
        logic [7:0]  ta[8];

        // reset state, readies forced low even with valids high
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #3;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_res", {16'b0, rsp_res}, 0);
        chk("rst_rsp_id", {31'b0, rsp_id}, 0);
        chk("rst_ready", {30'b0, req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // unsigned 0xFF*0x02, then check two-cycle latency
        @(posedge clk); #1;
        drive(0, 1, 8'hFF, 8'h02, 0);
        @(negedge clk);
        chk("u_accept", {31'b0, req0_ready}, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("u_lat1", {31'b0, rsp_valid}, 0);
        @(negedge clk);
        chk("u_valid", {31'b0, rsp_valid}, 1);
        chk("u_id", {31'b0, rsp_id}, 0);
        chk("u_res", {16'b0, rsp_res}, 32'h01FE);

        // signed multiplies
        @(posedge clk); #1;
        drive(0, 1, 8'hFF, 8'h02, 1);
        @(posedge clk); #1;
        drive(0, 1, 8'h80, 8'h80, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s_res1", {15'b0, rsp_valid, rsp_res}, {15'b0, 1'b1, 16'hFFFE});
        @(negedge clk);
        chk("s_res2", {15'b0, rsp_valid, rsp_res}, {15'b0, 1'b1, 16'h4000});
        drain();

        // contention: both requesters hold four distinct requests each
        do_reset();
        rsp_log.delete();
        for (int i = 0; i < 8; i++) ta[i] = 8'(8'h11 * (i + 1));
        i0 = 0; i1 = 0; k = 0;
        while ((i0 < 4 || i1 < 4) && k < 40) begin
            @(posedge clk); #1;
            drive(0, i0 < 4, ta[i0 & 7], 8'h03, 0);
            drive(1, i1 < 4, ta[(i1 + 4) & 7], 8'h05, 1);
            @(negedge clk);
            if (req0_valid & req0_ready) begin ord.push_back(1'b0); i0++; end
            if (req1_valid & req1_ready) begin ord.push_back(1'b1); i1++; end
            k++;
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drain();
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) exp_ord[i] = (i >= 4);
`else
        for (int i = 0; i < 8; i++) exp_ord[i] = i[0];
`endif
        chk("cont_count", ord.size(), 8);
        chk("cont_rsp_count", rsp_log.size(), 8);
        for (int i = 0; i < 8 && i < ord.size() && i < rsp_log.size(); i++) begin
            chk("cont_acc_order", {31'b0, ord[i]}, {31'b0, exp_ord[i]});
            chk("cont_rsp_order", {31'b0, rsp_log[i]}, {31'b0, exp_ord[i]});
        end

        // backpressure: capacity of two, stable response while stalled
        rsp_ready = 1'b0;
        rsp_log.delete();
        c = 0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0 || acc0) drive(0, 1, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            if (req0_ready) c++;
            if (rsp_valid && held === 16'b0) held = rsp_res;
            else if (rsp_valid) chk("bp_stable", {16'b0, rsp_res}, {16'b0, held});
        end
        chk("bp_accepted", c, 2);
        chk("bp_ready_low", {31'b0, req0_ready}, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        drain();
        chk("bp_rsp_count", rsp_log.size(), 2);

        // async reset with both stages full
        rsp_ready = 1'b0;
        c = 0; k = 0;
        while (c < 2 && k < 10) begin
            @(posedge clk); #1;
            if (c == 0 || acc0) drive(0, 1, 8'($urandom), 8'($urandom), 0);
            drive(1, 1, 8'h21, 8'h07, 0);
            @(negedge clk);
            c += int'(req0_ready) + int'(req1_ready);
            k++;
        end
        @(negedge clk);
        chk("mr_full", {31'b0, rsp_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mr_rsp_res", {16'b0, rsp_res}, 0);
        chk("mr_ready", {30'b0, req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mr_first_grant", {30'b0, req0_ready, req1_ready}, 32'b10);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drain();

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) drive(0, 1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
            if (!req1_valid || acc1) drive(1, 1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
            rsp_ready = 1'($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
